// File: rtl/mem_burst_rw_controller.sv
// Burst read/write controller in front of a register-file scratch memory.
// Handles per-beat handshakes, address auto-increment/wrap and sticky error codes.
module mem_burst_rw_controller #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 6,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned LENW  = 4,
  parameter int unsigned TMO   = 15,
  parameter int unsigned WRAP  = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wr_req,
  input  logic            i_rd_req,
  input  logic [AW-1:0]   i_addr,
  input  logic [LENW-1:0] i_len,
  output logic            o_ack,
  input  logic [DW-1:0]   i_wr_data,
  input  logic            i_wr_valid,
  output logic            o_wr_ready,
  output logic [DW-1:0]   o_rd_data,
  output logic            o_rd_valid,
  input  logic            i_rd_ready,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic [2:0]      o_err_code,
  input  logic            i_err_ack
);

  localparam int unsigned TW = $clog2(TMO + 1);
  localparam int unsigned EW = AW + LENW + 1;

  localparam logic [2:0] CodeNone  = 3'd0;
  localparam logic [2:0] CodeWrTmo = 3'd1;
  localparam logic [2:0] CodeRdTmo = 3'd2;
  localparam logic [2:0] CodeZero  = 3'd3;
  localparam logic [2:0] CodeRange = 3'd4;

  typedef enum logic [1:0] {StIdle, StWr, StRd, StErr} state_e;

  state_e          state_q;
  logic [AW-1:0]   cur_q;
  logic [LENW-1:0] len_q;
  logic [LENW-1:0] cnt_q;
  logic [TW-1:0]   tmr_q;
  logic            ack_q;
  logic            done_q;
  logic [2:0]      code_q;

  logic [DW-1:0]   mem [DEPTH];

  logic            wr_beat;
  logic            rd_beat;
  logic            beat;
  logic            last_beat;
  logic            tmo_hit;
  logic [EW-1:0]   end_addr;
  logic            range_err;
  logic [AW-1:0]   addr_nxt;

  always_comb begin
    wr_beat   = (state_q == StWr) && i_wr_valid;
    rd_beat   = (state_q == StRd) && i_rd_ready;
    beat      = wr_beat || rd_beat;
    last_beat = (cnt_q == (len_q - LENW'(1)));
    tmo_hit   = (tmr_q == TW'(TMO - 1));
    // Widened so start + length cannot overflow before the range compare.
    end_addr  = EW'(i_addr) + EW'(i_len);
    range_err = (EW'(i_addr) >= EW'(DEPTH)) ||
                ((WRAP == 0) && (end_addr > EW'(DEPTH)));
    addr_nxt  = (cur_q == AW'(DEPTH - 1)) ? '0 : cur_q + AW'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      cur_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      code_q  <= CodeNone;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_wr_req || i_rd_req) begin
            if (i_len == '0) begin
              state_q <= StErr;
              code_q  <= CodeZero;
            end else if (range_err) begin
              state_q <= StErr;
              code_q  <= CodeRange;
            end else begin
              cur_q   <= i_addr;
              len_q   <= i_len;
              cnt_q   <= '0;
              tmr_q   <= '0;
              ack_q   <= 1'b1;
              // Write wins a tie; the read requester must keep asserting.
              state_q <= i_wr_req ? StWr : StRd;
            end
          end
        end
        StWr, StRd: begin
          if (beat) begin
            cur_q <= addr_nxt;
            cnt_q <= cnt_q + LENW'(1);
            tmr_q <= '0;
            if (last_beat) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end else if (tmo_hit) begin
            state_q <= StErr;
            code_q  <= (state_q == StWr) ? CodeWrTmo : CodeRdTmo;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        StErr: begin
          if (i_err_ack) begin
            state_q <= StIdle;
            code_q  <= CodeNone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (wr_beat) begin
      mem[cur_q] <= i_wr_data;
    end
  end

  always_comb begin
    o_ack      = ack_q;
    o_done     = done_q;
    o_busy     = (state_q == StWr) || (state_q == StRd);
    o_wr_ready = (state_q == StWr);
    o_rd_valid = (state_q == StRd);
    o_rd_data  = (state_q == StRd) ? mem[cur_q] : '0;
    o_err      = (state_q == StErr);
    o_err_code = code_q;
  end

endmodule

// File: tb/tb_mem_burst_rw_controller.sv
// Directed bench: a transaction-level model checked every cycle, plus literal
// expectations for the data, handshakes and error codes of each scenario.
module tb_mem_burst_rw_controller;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int LENW  = 4;
  localparam int TMO   = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_req = 1'b0;
  logic            rd_req = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [LENW-1:0] len = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            wr_valid = 1'b0;
  logic            rd_ready = 1'b0;
  logic            err_ack = 1'b0;

  logic            o_ack, o_wr_ready, o_rd_valid, o_busy, o_done, o_err;
  logic [DW-1:0]   o_rd_data;
  logic [2:0]      o_err_code;

  logic            nw_ack, nw_wr_ready, nw_rd_valid, nw_busy, nw_done, nw_err;
  logic [DW-1:0]   nw_rd_data;
  logic [2:0]      nw_err_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_burst_rw_controller #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .LENW(LENW), .TMO(TMO), .WRAP(1)
  ) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_wr_req(wr_req), .i_rd_req(rd_req),
    .i_addr(addr), .i_len(len), .o_ack(o_ack), .i_wr_data(wr_data),
    .i_wr_valid(wr_valid), .o_wr_ready(o_wr_ready), .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(rd_ready), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code), .i_err_ack(err_ack)
  );

  // Same stimulus, but a burst crossing the top of memory is an error here.
  mem_burst_rw_controller #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .LENW(LENW), .TMO(TMO), .WRAP(0)
  ) u_nw (
    .i_clk(clk), .i_reset(rst_n), .i_wr_req(wr_req), .i_rd_req(rd_req),
    .i_addr(addr), .i_len(len), .o_ack(nw_ack), .i_wr_data(wr_data),
    .i_wr_valid(wr_valid), .o_wr_ready(nw_wr_ready), .o_rd_data(nw_rd_data),
    .o_rd_valid(nw_rd_valid), .i_rd_ready(rd_ready), .o_busy(nw_busy),
    .o_done(nw_done), .o_err(nw_err), .o_err_code(nw_err_code), .i_err_ack(err_ack)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Model: phase 0 idle, 1 writing, 2 reading, 3 error. Memory -1 = unknown.
  int m_phase = 0;
  int m_addr  = 0;
  int m_left  = 0;
  int m_stall = 0;
  int m_code  = 0;
  int m_ack   = 0;
  int m_done  = 0;
  int mm [DEPTH];

  function automatic void model_reset();
    m_phase = 0; m_addr = 0; m_left = 0; m_stall = 0;
    m_code = 0; m_ack = 0; m_done = 0;
  endfunction

  function automatic void model_step();
    bit took;
    m_ack  = 0;
    m_done = 0;
    case (m_phase)
      0: if (wr_req || rd_req) begin
        if (len == 0) begin
          m_phase = 3; m_code = 3;
        end else if (int'(addr) >= DEPTH) begin
          m_phase = 3; m_code = 4;
        end else begin
          m_phase = wr_req ? 1 : 2;
          m_addr  = int'(addr);
          m_left  = int'(len);
          m_stall = 0;
          m_ack   = 1;
        end
      end
      1, 2: begin
        took = (m_phase == 1) ? wr_valid : rd_ready;
        if (took) begin
          if (m_phase == 1) mm[m_addr] = int'(wr_data);
          m_addr  = (m_addr + 1) % DEPTH;
          m_left  = m_left - 1;
          m_stall = 0;
          if (m_left == 0) begin
            m_phase = 0; m_done = 1;
          end
        end else begin
          m_stall = m_stall + 1;
          if (m_stall == TMO) begin
            m_code  = (m_phase == 1) ? 1 : 2;
            m_phase = 3;
          end
        end
      end
      3: if (err_ack) begin
        m_phase = 0; m_code = 0;
      end
      default: m_phase = 0;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = -1;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("ack", o_ack, m_ack);
      chk("done", o_done, m_done);
      chk("busy", o_busy, (m_phase == 1 || m_phase == 2));
      chk("wr_ready", o_wr_ready, (m_phase == 1));
      chk("rd_valid", o_rd_valid, (m_phase == 2));
      chk("err", o_err, (m_phase == 3));
      chk("err_code", o_err_code, m_code);
      if (m_phase != 2) chk("rd_data_idle", o_rd_data, 0);
      else if (mm[m_addr] >= 0) chk("rd_data", o_rd_data, mm[m_addr]);
    end
  end

  logic          got_ack, got_wrr, got_nw_ack, got_nw_err;
  logic [2:0]    got_nw_code;
  logic [DW-1:0] cap [4];
  logic [DW-1:0] nwcap [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input bit w, input bit r, input int a, input int l);
    wr_req = w;
    rd_req = r;
    addr   = AW'(a);
    len    = LENW'(l);
    tick();
    wr_req      = 1'b0;
    rd_req      = 1'b0;
    got_ack     = o_ack;
    got_wrr     = o_wr_ready;
    got_nw_ack  = nw_ack;
    got_nw_err  = nw_err;
    got_nw_code = nw_err_code;
  endtask

  task automatic wr_burst(input int a, input int l, input int base, input bit toggle,
                          input bit both);
    int n;
    start_burst(1'b1, both, a, l);
    n = 0;
    for (int g = 0; g < 64 && n < l; g++) begin
      wr_valid = toggle ? (g % 2 == 0) : 1'b1;
      wr_data  = DW'(base + n);
      tick();
      if (wr_valid) n++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic rd_burst(input int a, input int l, input int stall);
    logic [DW-1:0] held;
    start_burst(1'b0, 1'b1, a, l);
    rd_ready = 1'b0;
    held = o_rd_data;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("rd_hold", o_rd_data, held);
    end
    for (int i = 0; i < l; i++) begin
      rd_ready = 1'b1;
      cap[i]   = o_rd_data;
      nwcap[i] = nw_rd_data;
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic pulse_err_ack();
    err_ack = 1'b1;
    tick();
    err_ack = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_code", o_err_code, 0);
    chk("rst_rd_valid", o_rd_valid, 0);
    rst_n = 1'b1;
    tick();

    // Basic write then read back
    wr_burst(5, 4, 'hA0, 1'b0, 1'b0);
    chk("wr_ack", got_ack, 1);
    chk("wr_done", o_done, 1);
    rd_burst(5, 4, 0);
    chk("rd_done", o_done, 1);
    chk("rd0", cap[0], 'hA0);
    chk("rd1", cap[1], 'hA1);
    chk("rd2", cap[2], 'hA2);
    chk("rd3", cap[3], 'hA3);

    // Wrap vs. range error
    wr_burst(62, 2, 'h50, 1'b0, 1'b0);
    wr_burst(0, 1, 'h52, 1'b0, 1'b0);
    wr_burst(62, 3, 'h60, 1'b0, 1'b0);
    chk("wrap_ack", got_ack, 1);
    chk("nw_no_ack", got_nw_ack, 0);
    chk("nw_err", got_nw_err, 1);
    chk("nw_code", got_nw_code, 4);
    pulse_err_ack();
    chk("nw_err_clr", nw_err, 0);
    chk("nw_code_clr", nw_err_code, 0);
    rd_burst(62, 2, 0);
    chk("wrap62", cap[0], 'h60);
    chk("wrap63", cap[1], 'h61);
    chk("nw62", nwcap[0], 'h50);
    chk("nw63", nwcap[1], 'h51);
    rd_burst(0, 1, 0);
    chk("wrap0", cap[0], 'h62);
    chk("nw0", nwcap[0], 'h52);

    // Stall just short of timeout, then exactly at it
    rd_burst(5, 2, TMO - 1);
    chk("stall_no_err", o_err, 0);
    chk("stall_rd0", cap[0], 'hA0);
    chk("stall_rd1", cap[1], 'hA1);
    start_burst(1'b0, 1'b1, 5, 2);
    rd_ready = 1'b0;
    repeat (TMO - 1) tick();
    chk("tmo_not_yet", o_err, 0);
    tick();
    chk("tmo_err", o_err, 1);
    chk("tmo_code", o_err_code, 2);
    pulse_err_ack();
    chk("tmo_clr_err", o_err, 0);
    chk("tmo_clr_code", o_err_code, 0);

    // Write priority and zero length
    wr_burst(30, 2, 'h70, 1'b0, 1'b1);
    chk("both_wr", got_wrr, 1);
    start_burst(1'b1, 1'b0, 10, 0);
    chk("zero_no_ack", got_ack, 0);
    chk("zero_err", o_err, 1);
    chk("zero_code", o_err_code, 3);
    pulse_err_ack();

    // Toggling valid
    wr_burst(40, 4, 'h80, 1'b1, 1'b0);
    chk("tog_done", o_done, 1);
    chk("tog_no_err", o_err, 0);
    rd_burst(40, 4, 0);
    chk("tog0", cap[0], 'h80);
    chk("tog3", cap[3], 'h83);

    // Reset in the middle of a write burst
    wr_burst(20, 4, 'h11, 1'b0, 1'b0);
    start_burst(1'b1, 1'b0, 20, 4);
    wr_valid = 1'b1;
    wr_data  = 'h21;
    tick();
    wr_data  = 'h22;
    tick();
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_wrr", o_wr_ready, 0);
    chk("mid_rst_done", o_done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", o_done, 0);
    rd_burst(20, 4, 0);
    chk("rst20", cap[0], 'h21);
    chk("rst21", cap[1], 'h22);
    chk("rst22", cap[2], 'h13);
    chk("rst23", cap[3], 'h14);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
